// File: rtl/polytris_timing_pkg.sv
// Shared timing types and defaults for the falling-piece gravity/lock logic.
package polytris_timing_pkg;

    typedef enum logic [1:0] {
        FALL      = 2'd0,
        GROUNDED  = 2'd1,
        LOCK_WAIT = 2'd2
    } gt_state_e;

    localparam int unsigned DEF_CNT_W           = 26;
    localparam int unsigned DEF_NUM_LEVELS      = 16;
    localparam int unsigned DEF_BASE_PERIOD     = 48000000;
    localparam int unsigned DEF_LEVEL_STEP      = 5000000;
    localparam int unsigned DEF_MIN_PERIOD      = 3000000;
    localparam int unsigned DEF_SOFT_PERIOD     = 700000;
    localparam int unsigned DEF_LOCK_PERIOD     = 25000000;
    localparam int unsigned DEF_MAX_LOCK_RESETS = 15;

    localparam int RESETS_W = 8;

    // max(base - lvl*step, minp) without wrapping when the product overshoots.
    function automatic logic [63:0] level_period(input logic [63:0] lvl,
                                                 input logic [63:0] base,
                                                 input logic [63:0] step,
                                                 input logic [63:0] minp);
        logic [63:0] prod;
        prod = lvl * step;
        if (base < minp || prod > base - minp)
            level_period = minp;
        else
            level_period = base - prod;
    endfunction

endpackage

// File: rtl/gravity_period_calc.sv
// Combinational active fall period: level period with floor, optionally capped by soft drop.
module gravity_period_calc
    import polytris_timing_pkg::*;
#(
    parameter int unsigned CNT_W       = DEF_CNT_W,
    parameter int unsigned LVL_W       = 4,
    parameter int unsigned BASE_PERIOD = DEF_BASE_PERIOD,
    parameter int unsigned LEVEL_STEP  = DEF_LEVEL_STEP,
    parameter int unsigned MIN_PERIOD  = DEF_MIN_PERIOD,
    parameter int unsigned SOFT_PERIOD = DEF_SOFT_PERIOD
) (
    input  logic [LVL_W-1:0] level_i,
    input  logic             soft_drop_i,
    output logic [CNT_W-1:0] ap_o
);

    localparam logic [CNT_W-1:0] SOFT_P = CNT_W'(SOFT_PERIOD);

    logic [CNT_W-1:0] lp;

    // The product of an LVL_W level and a CNT_W step fits in the 64-bit helper.
    assign lp   = CNT_W'(level_period(64'(level_i), 64'(BASE_PERIOD),
                                      64'(LEVEL_STEP), 64'(MIN_PERIOD)));
    assign ap_o = (soft_drop_i && SOFT_P < lp) ? SOFT_P : lp;

endmodule

// File: rtl/gravity_lock_timer.sv
// Gravity tick generator and lock-delay timer with bounded move resets.
module gravity_lock_timer
    import polytris_timing_pkg::*;
#(
    parameter int unsigned CNT_W           = DEF_CNT_W,
    parameter int unsigned NUM_LEVELS      = DEF_NUM_LEVELS,
    parameter int unsigned BASE_PERIOD     = DEF_BASE_PERIOD,
    parameter int unsigned LEVEL_STEP      = DEF_LEVEL_STEP,
    parameter int unsigned MIN_PERIOD      = DEF_MIN_PERIOD,
    parameter int unsigned SOFT_PERIOD     = DEF_SOFT_PERIOD,
    parameter int unsigned LOCK_PERIOD     = DEF_LOCK_PERIOD,
    parameter int unsigned MAX_LOCK_RESETS = DEF_MAX_LOCK_RESETS,
    localparam int unsigned LVL_W          = $clog2(NUM_LEVELS)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             en,
    input  logic [LVL_W-1:0] level,
    input  logic             soft_drop,
    input  logic             grounded,
    input  logic             move_ack,
    input  logic             lock_ack,
    output logic             fall_tick,
    output logic             lock_req,
    output logic [1:0]       state
);

    localparam logic [CNT_W-1:0]    LOCK_LAST = CNT_W'(LOCK_PERIOD - 1);
    localparam logic [RESETS_W-1:0] MAX_R     = RESETS_W'(MAX_LOCK_RESETS);

    if ((64'(BASE_PERIOD) >> CNT_W) != 0 || (64'(SOFT_PERIOD) >> CNT_W) != 0 ||
        (64'(LOCK_PERIOD) >> CNT_W) != 0) begin : g_bad_width
        $error("gravity_lock_timer: a period does not fit in CNT_W bits");
    end
    if (MIN_PERIOD < 1 || SOFT_PERIOD < 1 || LOCK_PERIOD < 1) begin : g_bad_min
        $error("gravity_lock_timer: periods must be at least 1");
    end
    if (MAX_LOCK_RESETS >= 256) begin : g_bad_resets
        $error("gravity_lock_timer: MAX_LOCK_RESETS must be below 256");
    end
    if (NUM_LEVELS < 2 || CNT_W + LVL_W > 64) begin : g_bad_levels
        $error("gravity_lock_timer: unsupported NUM_LEVELS/CNT_W combination");
    end

    gt_state_e           state_q, state_d;
    logic [CNT_W-1:0]    fcnt_q, fcnt_d;
    logic [CNT_W-1:0]    lcnt_q, lcnt_d;
    logic [RESETS_W-1:0] resets_q, resets_d;
    logic                fall_tick_q, fall_tick_d;
    logic                lock_req_q, lock_req_d;

    logic [LVL_W-1:0]    lvl_c;
    logic [CNT_W-1:0]    ap;
    logic                move_ok;

    assign lvl_c = ({1'b0, level} >= (LVL_W+1)'(NUM_LEVELS)) ? LVL_W'(NUM_LEVELS - 1) : level;

    gravity_period_calc #(
        .CNT_W       (CNT_W),
        .LVL_W       (LVL_W),
        .BASE_PERIOD (BASE_PERIOD),
        .LEVEL_STEP  (LEVEL_STEP),
        .MIN_PERIOD  (MIN_PERIOD),
        .SOFT_PERIOD (SOFT_PERIOD)
    ) u_period (
        .level_i     (lvl_c),
        .soft_drop_i (soft_drop),
        .ap_o        (ap)
    );

    assign move_ok = move_ack && (resets_q < MAX_R);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= FALL;
            fcnt_q      <= '0;
            lcnt_q      <= '0;
            resets_q    <= '0;
            fall_tick_q <= 1'b0;
            lock_req_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            fcnt_q      <= fcnt_d;
            lcnt_q      <= lcnt_d;
            resets_q    <= resets_d;
            fall_tick_q <= fall_tick_d;
            lock_req_q  <= lock_req_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        fcnt_d      = fcnt_q;
        lcnt_d      = lcnt_q;
        resets_d    = resets_q;
        fall_tick_d = 1'b0;
        lock_req_d  = lock_req_q;

        // The lock handshake completes even while paused.
        if (state_q == LOCK_WAIT && lock_ack) begin
            state_d    = FALL;
            fcnt_d     = '0;
            lcnt_d     = '0;
            resets_d   = '0;
            lock_req_d = 1'b0;
        end else if (en) begin
            case (state_q)
                FALL: begin
                    if (grounded) begin
                        state_d = GROUNDED;
                        fcnt_d  = '0;
                        lcnt_d  = '0;
                    end else if (fcnt_q >= ap - CNT_W'(1)) begin
                        fcnt_d      = '0;
                        fall_tick_d = 1'b1;
                    end else begin
                        fcnt_d = fcnt_q + CNT_W'(1);
                    end
                end
                GROUNDED: begin
                    fcnt_d = '0;
                    if (!grounded) begin
                        state_d = FALL;
                        lcnt_d  = '0;
                    end else if (move_ok) begin
                        lcnt_d   = '0;
                        resets_d = resets_q + RESETS_W'(1);
                    end else if (lcnt_q == LOCK_LAST) begin
                        state_d    = LOCK_WAIT;
                        lock_req_d = 1'b1;
                    end else begin
                        lcnt_d = lcnt_q + CNT_W'(1);
                    end
                end
                LOCK_WAIT: ;
                default: state_d = FALL;
            endcase
        end
    end

    assign fall_tick = fall_tick_q;
    assign lock_req  = lock_req_q;
    assign state     = state_q;

endmodule

// File: tb/tb_gravity_lock_timer.sv
// Scoreboard bench: expected tick/lock cycles are queued as stimulus is driven.
module tb_gravity_lock_timer;

    localparam int BASE = 20, STEP = 4, MINP = 4, SOFT = 3, LOCKP = 10, MAXR = 2, NLVL = 8;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       en = 1'b1;
    logic [2:0] level = '0;
    logic       soft_drop = 1'b0;
    logic       grounded = 1'b0;
    logic       move_ack = 1'b0;
    logic       lock_ack = 1'b0;
    logic       fall_tick, lock_req;
    logic [1:0] state;

    int n_chk = 0, n_fail = 0;
    int cyc = 0, t0 = 0;
    bit mon_en = 1'b0;
    logic lock_prev = 1'b0;
    int tick_q[$];
    int lock_q[$];
    int e_tick, e_lock;

    gravity_lock_timer #(
        .CNT_W(26), .NUM_LEVELS(NLVL), .BASE_PERIOD(BASE), .LEVEL_STEP(STEP),
        .MIN_PERIOD(MINP), .SOFT_PERIOD(SOFT), .LOCK_PERIOD(LOCKP), .MAX_LOCK_RESETS(MAXR)
    ) dut (
        .CLK(CLK), .RESET(RESET), .en(en), .level(level), .soft_drop(soft_drop),
        .grounded(grounded), .move_ack(move_ack), .lock_ack(lock_ack),
        .fall_tick(fall_tick), .lock_req(lock_req), .state(state)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, act, exp, cyc - t0);
        end
    endtask

    always @(negedge CLK) begin
        if (mon_en) begin
            if (fall_tick) begin
                if (tick_q.size() > 0) begin
                    e_tick = tick_q.pop_front();
                    chk("tick_cycle", cyc - t0, e_tick - t0);
                end else
                    chk("tick_pending", tick_q.size(), 1);
            end
            if (lock_req && !lock_prev) begin
                if (lock_q.size() > 0) begin
                    e_lock = lock_q.pop_front();
                    chk("lock_cycle", cyc - t0, e_lock - t0);
                end else
                    chk("lock_pending", lock_q.size(), 1);
            end
        end
        lock_prev = lock_req;
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic run_until(input int c);
        while (cyc < c) step();
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        RESET = 1'b1;
        en = 1'b1; level = '0; soft_drop = 1'b0; grounded = 1'b0;
        move_ack = 1'b0; lock_ack = 1'b0;
        step();
        step();
        tick_q.delete();
        lock_q.delete();
        RESET = 1'b0;
        t0 = cyc;
        mon_en = 1'b1;
        @(negedge CLK);
        chk("rst_state", int'(state), 0);
        chk("rst_tick", int'(fall_tick), 0);
        chk("rst_lock", int'(lock_req), 0);
    endtask

    function automatic int exp_ap(input int l, input bit s);
        int p;
        p = BASE - l * STEP;
        if (p < MINP) p = MINP;
        if (s && SOFT < p) p = SOFT;
        return p;
    endfunction

    task automatic run_ticks(input int l, input bit s, input int n);
        int p;
        do_reset();
        level = 3'(l);
        soft_drop = s;
        p = exp_ap(l, s);
        for (int k = 1; k <= n; k++) tick_q.push_back(t0 + k * p);
        run_until(t0 + n * p + p / 2);
        chk("ticks_missed", tick_q.size(), 0);
    endtask

    int acks[3];
    int ls, r, lock_exp;

    initial begin
        // steady gravity at several levels, including the floor and no-wrap cases
        run_ticks(0, 1'b0, 3);
        run_ticks(3, 1'b0, 3);
        run_ticks(4, 1'b0, 3);
        run_ticks(5, 1'b0, 4);
        run_ticks(7, 1'b0, 4);
        run_ticks(2, 1'b1, 4);

        // soft drop engaged mid-count
        do_reset();
        run_until(t0 + 10);
        soft_drop = 1'b1;
        tick_q.push_back(t0 + 11);
        tick_q.push_back(t0 + 14);
        tick_q.push_back(t0 + 17);
        tick_q.push_back(t0 + 20);
        run_until(t0 + 21);
        chk("soft_missed", tick_q.size(), 0);

        // plain lock delay then acknowledge
        do_reset();
        run_until(t0 + 5);
        grounded = 1'b1;
        lock_q.push_back(t0 + 5 + 1 + LOCKP);
        step();
        @(negedge CLK);
        chk("grounded_state", int'(state), 1);
        run_until(t0 + 20);
        lock_ack = 1'b1;
        grounded = 1'b0;
        @(negedge CLK);
        chk("lockwait_state", int'(state), 2);
        chk("lockwait_req", int'(lock_req), 1);
        step();
        lock_ack = 1'b0;
        @(negedge CLK);
        chk("ack_state", int'(state), 0);
        chk("ack_req", int'(lock_req), 0);
        tick_q.push_back(t0 + 21 + BASE);
        run_until(t0 + 45);
        chk("lock_missed", lock_q.size(), 0);
        chk("post_ack_missed", tick_q.size(), 0);

        // move resets: two accepted, third beyond budget
        do_reset();
        run_until(t0 + 2);
        grounded = 1'b1;
        ls = t0 + 3;
        r = 0;
        for (int k = 0; k < 3; k++) begin
            acks[k] = ls + 5;
            if (r < MAXR) begin
                ls = acks[k] + 1;
                r++;
            end
        end
        lock_exp = ls + LOCKP;
        lock_q.push_back(lock_exp);
        for (int k = 0; k < 3; k++) begin
            run_until(acks[k]);
            move_ack = 1'b1;
            step();
            move_ack = 1'b0;
        end
        run_until(lock_exp + 2);
        chk("moves_lock_missed", lock_q.size(), 0);
        @(negedge CLK);
        chk("moves_state", int'(state), 2);
        // reset while waiting for the lock acknowledge
        step();
        RESET = 1'b1;
        mon_en = 1'b0;
        step();
        @(negedge CLK);
        chk("rst_lw_state", int'(state), 0);
        chk("rst_lw_req", int'(lock_req), 0);
        chk("rst_lw_tick", int'(fall_tick), 0);

        // pause stretches the interval by the paused cycle count
        do_reset();
        level = 3'd3;
        tick_q.push_back(t0 + 8);
        tick_q.push_back(t0 + 23);
        tick_q.push_back(t0 + 31);
        run_until(t0 + 10);
        en = 1'b0;
        run_until(t0 + 17);
        en = 1'b1;
        run_until(t0 + 34);
        chk("pause_missed", tick_q.size(), 0);

        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/gravity_lock_timer.md
# gravity_lock_timer

Parametrised gravity and lock-delay timer for the falling piece. It sits between the game-control FSM and the piece-movement logic. It emits single-cycle `fall_tick` pulses at a level-dependent or soft-drop rate. Once the piece is grounded, it runs a lock-delay timer with a bounded number of move resets. It then raises `lock_req` until the piece handler acknowledges.

## Interface
- `CNT_W`, default 26: width of the fall and lock counters.
- `NUM_LEVELS`, default 16: number of distinct levels. `LVL_W = $clog2(NUM_LEVELS)` is derived.
- `BASE_PERIOD`, default 48000000: fall period at level 0, in cycles.
- `LEVEL_STEP`, default 5000000: period reduction per level.
- `MIN_PERIOD`, default 3000000: floor on the level period.
- `SOFT_PERIOD`, default 700000: fall period while soft drop is held.
- `LOCK_PERIOD`, default 25000000: lock delay, in cycles.
- `MAX_LOCK_RESETS`, default 15: move resets allowed per piece.
- `CLK  in  1`: clock.
- `RESET  in  1`: reset, synchronous, active-high.
- `en  in  1`: run enable. Low means paused.
- `level  in  LVL_W`: current level. Values ≥ `NUM_LEVELS` clamp to `NUM_LEVELS-1`.
- `soft_drop  in  1`: soft drop held.
- `grounded  in  1`: piece cannot move down.
- `move_ack  in  1`: one-cycle pulse when the piece moved or rotated successfully.
- `lock_ack  in  1`: one-cycle pulse when the piece handler has consumed the lock.
- `fall_tick  out  1`: one-cycle pulse meaning "move piece down".
- `lock_req  out  1`: lock request, level-held until `lock_ack`.
- `state  out  2`: current FSM state, for debug and status.

## Operation
- Level period: `lp = max(BASE_PERIOD - L*LEVEL_STEP, MIN_PERIOD)`, where L is the clamped level.
  - The product is computed in CNT_W+LVL_W bits.
  - If `L*LEVEL_STEP > BASE_PERIOD - MIN_PERIOD`, the result is `MIN_PERIOD`. There is no wrap.
- Active period: `ap = soft_drop ? min(SOFT_PERIOD, lp) : lp`.
- FSM states are FALL = 0, GROUNDED = 1 and LOCK_WAIT = 2.
- FALL:
  - `fcnt` increments each enabled cycle.
  - When `fcnt >= ap-1`: `fcnt <= 0` and `fall_tick <= 1`. The `>=` handles a level change or soft-drop engage mid-count, which then ticks on the next edge.
  - `grounded = 1` moves to GROUNDED with `fcnt <= 0` and `lcnt <= 0`. In that cycle `grounded` takes priority and no tick is issued.
- GROUNDED:
  - `fcnt` is held at 0 and no `fall_tick` is issued.
  - `lcnt` increments each enabled cycle.
  - `move_ack` with `resets < MAX_LOCK_RESETS`: `lcnt <= 0` and `resets++`.
  - `move_ack` with the reset budget exhausted is ignored.
  - `grounded = 0` returns to FALL with `fcnt <= 0`. `lcnt` is cleared and `resets` is kept.
  - When `lcnt == LOCK_PERIOD-1` and no accepted `move_ack` is present: go to LOCK_WAIT and set `lock_req <= 1`.
  - An accepted `move_ack` beats lock expiry in the same cycle. `grounded = 0` beats both.
- LOCK_WAIT:
  - `lock_req` stays high and no ticks are issued.
  - `lock_ack` sets `lock_req <= 0`, clears `fcnt`, `lcnt` and `resets`, and moves to FALL.
- `lock_ack` outside LOCK_WAIT is ignored.
- `en = 0`: `fcnt`, `lcnt`, `resets` and the state freeze, and no `fall_tick` is issued. `lock_req` holds its value, and `lock_ack` is still accepted in LOCK_WAIT.
- Elaboration assertions:
  - `BASE_PERIOD`, `SOFT_PERIOD` and `LOCK_PERIOD` are all < 2^CNT_W.
  - `MIN_PERIOD ≥ 1`, `SOFT_PERIOD ≥ 1` and `LOCK_PERIOD ≥ 1`.
  - `MAX_LOCK_RESETS < 256`. `resets` is 8 bits wide.

## Timing
- Reset values: state = FALL, `fcnt = lcnt = resets = 0`, `fall_tick = 0`, `lock_req = 0`.
- Reset mid-operation, including in LOCK_WAIT, aborts to these values on the next edge.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Fall tick timing, with constant `ap` and `en`:
  - The first `fall_tick` is high in cycle `ap` after reset release, where cycle 0 is the first cycle with `RESET = 0`.
  - After that, ticks occur every `ap` cycles.
- Lock timing: with `grounded` rising in cycle g and no `move_ack`, the FSM is in GROUNDED from cycle g+1 and `lock_req` goes high in cycle g+1+LOCK_PERIOD.
- `lock_ack` in cycle a gives `lock_req = 0` and state = FALL in cycle a+1. The next fall tick follows `ap` cycles later.
- Pause cycles extend every interval by exactly the number of cycles `en` was low.

## Structure
- Shared package `polytris_timing_pkg`:
  - `gt_state_e` enum: FALL, GROUNDED, LOCK_WAIT.
  - The default period constants.
  - A saturating function `level_period(L)`.
- One sub-module, `gravity_period_calc`. It is combinational: clamped level and soft_drop in, `ap` out.
- The FSM and counters live in `gravity_lock_timer`.

## Test plan
Bench parameters: BASE_PERIOD = 20, LEVEL_STEP = 4, MIN_PERIOD = 4, SOFT_PERIOD = 3, LOCK_PERIOD = 10, MAX_LOCK_RESETS = 2, NUM_LEVELS = 8.
- Reset release with level 0 → `fall_tick` in cycles 20, 40 and 60 only.
- Level 3 → period 8. Level 5 and level 7 → period 4 via the floor, with no wrap.
- Level 0, raise `soft_drop` at `fcnt = 10` → tick on the next edge, then every 3 cycles.
- Raise `grounded`, apply no moves → `lock_req` high exactly 10 cycles after entering GROUNDED. `lock_ack` → FALL, and the next tick comes 20 cycles later.
- While grounded, apply 3 `move_ack` pulses at `lcnt = 5` → the first two restart `lcnt` and the third is ignored. `lock_req` is asserted at the predicted cycle.
- Drop `en` for 7 cycles mid-count → the tick is delayed by exactly 7 cycles. Assert RESET in LOCK_WAIT → all outputs are 0 and state = FALL next cycle.
